// File: rtl/rv32i_types.sv
// Shared RV32I types: base opcodes and the fetch-to-dispatch queue entry.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_fence = 7'b0001111,
        op_sys   = 7'b1110011
    } rv32i_opcode_t;

    localparam int IQ_PC_W = 32;

    typedef struct packed {
        logic [31:0]         instr;
        logic [IQ_PC_W-1:0]  pc;
    } iq_entry_t;

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I field extractor with opcode-selected, sign-extended immediate.
module rv32i_decoder
    import rv32i_types::*;
(
    input  logic [31:0]   instr_i,
    output rv32i_opcode_t opcode_o,
    output logic [2:0]    funct3_o,
    output logic [6:0]    funct7_o,
    output logic [4:0]    rs1_o,
    output logic [4:0]    rs2_o,
    output logic [4:0]    rd_o,
    output logic [31:0]   imm_o
);

    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

    assign opcode_o = rv32i_opcode_t'(instr_i[6:0]);
    assign funct3_o = instr_i[14:12];
    assign funct7_o = instr_i[31:25];
    assign rs1_o    = instr_i[19:15];
    assign rs2_o    = instr_i[24:20];
    assign rd_o     = instr_i[11:7];

    assign i_imm = {{20{instr_i[31]}}, instr_i[31:20]};
    assign s_imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign b_imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign u_imm = {instr_i[31:12], 12'h000};
    assign j_imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        imm_o = '0;
        case (opcode_o)
            op_lui, op_auipc:        imm_o = u_imm;
            op_jal:                  imm_o = j_imm;
            op_br:                   imm_o = b_imm;
            op_store:                imm_o = s_imm;
            op_jalr, op_load, op_imm: imm_o = i_imm;
            default:                 imm_o = '0;
        endcase
    end

endmodule

// File: rtl/instr_decode_queue.sv
// Instruction FIFO between fetch and dispatch; head entry decoded combinationally.
// One-cycle write-to-visible latency, no fall-through; enq_ready is !full only.
module instr_decode_queue
    import rv32i_types::*;
#(
    parameter  int DEPTH = 8,
    parameter  int PC_W  = 32,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [31:0]       enq_instr,
    input  logic [PC_W-1:0]   enq_pc,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [PC_W-1:0]   deq_pc,
    output rv32i_opcode_t     deq_opcode,
    output logic [2:0]        deq_funct3,
    output logic [6:0]        deq_funct7,
    output logic [4:0]        deq_rs1,
    output logic [4:0]        deq_rs2,
    output logic [4:0]        deq_rd,
    output logic [31:0]       deq_imm,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    iq_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full, empty, enq_fire, deq_fire;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign enq_fire = enq_valid && !full;
    assign deq_fire = deq_ready && !empty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) tail_d = tail_q + PTR_W'(1);
            if (deq_fire) head_d = head_q + PTR_W'(1);
            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; the empty gating below hides uninitialised entries.
    always_ff @(posedge clk) begin
        if (enq_fire && !flush) begin
            mem_q[tail_q] <= '{instr: enq_instr, pc: IQ_PC_W'(enq_pc)};
        end
    end

    iq_entry_t      head;
    rv32i_opcode_t  dec_opcode;
    logic [2:0]     dec_funct3;
    logic [6:0]     dec_funct7;
    logic [4:0]     dec_rs1, dec_rs2, dec_rd;
    logic [31:0]    dec_imm;

    assign head = mem_q[head_q];

    rv32i_decoder u_dec (
        .instr_i  (head.instr),
        .opcode_o (dec_opcode),
        .funct3_o (dec_funct3),
        .funct7_o (dec_funct7),
        .rs1_o    (dec_rs1),
        .rs2_o    (dec_rs2),
        .rd_o     (dec_rd),
        .imm_o    (dec_imm)
    );

    assign enq_ready = !full;
    assign deq_valid = !empty;
    assign count     = count_q;

    always_comb begin
        deq_pc     = '0;
        deq_opcode = rv32i_opcode_t'(7'h00);
        deq_funct3 = '0;
        deq_funct7 = '0;
        deq_rs1    = '0;
        deq_rs2    = '0;
        deq_rd     = '0;
        deq_imm    = '0;
        if (!empty) begin
            deq_pc     = PC_W'(head.pc);
            deq_opcode = dec_opcode;
            deq_funct3 = dec_funct3;
            deq_funct7 = dec_funct7;
            deq_rs1    = dec_rs1;
            deq_rs2    = dec_rs2;
            deq_rd     = dec_rd;
            deq_imm    = dec_imm;
        end
    end

endmodule

// File: tb/tb_instr_decode_queue.sv
// Bench for instr_decode_queue: decode table, hand-written corner sequences, random traffic vs a queue model.
module tb_instr_decode_queue;

    logic        clk, rst, flush;
    logic        enq_valid, enq_ready, deq_valid, deq_ready;
    logic [31:0] enq_instr, enq_pc, deq_pc, deq_imm;
    logic [6:0]  deq_opcode, deq_funct7;
    logic [2:0]  deq_funct3;
    logic [4:0]  deq_rs1, deq_rs2, deq_rd;
    logic [3:0]  count;

    instr_decode_queue #(.DEPTH(8), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_instr(enq_instr), .enq_pc(enq_pc),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc),
        .deq_opcode(deq_opcode), .deq_funct3(deq_funct3), .deq_funct7(deq_funct7),
        .deq_rs1(deq_rs1), .deq_rs2(deq_rs2), .deq_rd(deq_rd), .deq_imm(deq_imm),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [63:0] mq [$];   // {instr, pc}, front = oldest

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [31:0] imm;
    } dec_vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        int v;
        case (w[6:0])
            7'h37, 7'h17: return w & 32'hFFFFF000;
            7'h6F: begin
                v = (w[31] ? -(1 << 20) : 0) + (int'(w[19:12]) << 12) + (int'(w[20]) << 11) + (int'(w[30:21]) << 1);
                return v;
            end
            7'h63: begin
                v = (w[31] ? -(1 << 12) : 0) + (int'(w[7]) << 11) + (int'(w[30:25]) << 5) + (int'(w[11:8]) << 1);
                return v;
            end
            7'h23: begin
                v = (w[31] ? -(1 << 11) : 0) + (int'(w[30:25]) << 5) + int'(w[11:7]);
                return v;
            end
            7'h67, 7'h03, 7'h13: begin
                v = (w[31] ? -(1 << 11) : 0) + int'(w[30:20]);
                return v;
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [63:0] ref_bus(input logic [31:0] w);
        return {w[6:0], w[14:12], w[31:25], w[19:15], w[24:20], w[11:7], ref_imm(w)};
    endfunction

    task automatic check_state(input string nm);
        logic [63:0] head;
        chk({nm, ".count"}, 64'(count), 64'(mq.size()));
        chk({nm, ".enq_ready"}, 64'(enq_ready), 64'(mq.size() < 8));
        chk({nm, ".deq_valid"}, 64'(deq_valid), 64'(mq.size() > 0));
        head = (mq.size() > 0) ? mq[0] : 64'h0;
        chk({nm, ".deq_pc"}, 64'(deq_pc), 64'(head[31:0]));
        chk({nm, ".decode"},
            {deq_opcode, deq_funct3, deq_funct7, deq_rs1, deq_rs2, deq_rd, deq_imm},
            (mq.size() > 0) ? ref_bus(head[63:32]) : 64'h0);
    endtask

    // Drive one cycle, update the model with pre-edge state, then check after the edge.
    task automatic cycle(input string nm, input logic ev, input logic dr, input logic fl,
                         input logic [31:0] ins, input logic [31:0] pc);
        enq_valid = ev; deq_ready = dr; flush = fl; enq_instr = ins; enq_pc = pc;
        if (fl) begin
            mq.delete();
        end else begin
            logic can_enq;
            can_enq = ev && (mq.size() < 8);
            if (dr && mq.size() > 0) void'(mq.pop_front());
            if (can_enq) mq.push_back({ins, pc});
        end
        @(posedge clk); #1;
        enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
        check_state(nm);
    endtask

    dec_vec_t vecs [9];
    logic [6:0] opcs [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] w;

        rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; enq_instr = '0; enq_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        rst = 1'b0;

        // Decode table (beq x0,x0,-4 encodes as 0xFE000EE3, so its b-immediate is -4).
        vecs[0] = '{32'hFFF00093, 7'h13, 5'd1,  32'hFFFFFFFF};
        vecs[1] = '{32'h800000EF, 7'h6F, 5'd1,  32'hFFF00000};
        vecs[2] = '{32'hFE000EE3, 7'h63, 5'd29, 32'hFFFFFFFC};
        vecs[3] = '{32'h123450B7, 7'h37, 5'd1,  32'h12345000};
        vecs[4] = '{32'hFFFFF097, 7'h17, 5'd1,  32'hFFFFF000};
        vecs[5] = '{32'hFE20AC23, 7'h23, 5'd24, 32'hFFFFFFF8};
        vecs[6] = '{32'h00412283, 7'h03, 5'd5,  32'h00000004};
        vecs[7] = '{32'h002081B3, 7'h33, 5'd3,  32'h00000000};
        vecs[8] = '{32'h00008067, 7'h67, 5'd0,  32'h00000000};
        for (int i = 0; i < 9; i++) begin
            cycle("tbl.enq", 1'b1, 1'b0, 1'b0, vecs[i].instr, 32'h2000 + 32'(i * 4));
            chk($sformatf("tbl%0d.opcode", i), 64'(deq_opcode), 64'(vecs[i].opc));
            chk($sformatf("tbl%0d.rd", i),     64'(deq_rd),     64'(vecs[i].rd));
            chk($sformatf("tbl%0d.imm", i),    64'(deq_imm),    64'(vecs[i].imm));
            cycle("tbl.deq", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        end

        // Asynchronous reset between edges with 3 entries held.
        for (int i = 0; i < 3; i++) cycle("rstmid.fill", 1'b1, 1'b0, 1'b0, 32'hFFF00093, 32'h40 + 32'(i * 4));
        #3 rst = 1'b1;
        #1;
        chk("rstmid.count", 64'(count), 64'd0);
        chk("rstmid.deq_valid", 64'(deq_valid), 64'd0);
        chk("rstmid.deq_imm", 64'(deq_imm), 64'd0);
        #2 rst = 1'b0;
        mq.delete();

        // Fill to capacity; the ninth offer is dropped.
        for (int i = 0; i < 8; i++) cycle("fill", 1'b1, 1'b0, 1'b0, 32'h00000013, 32'h100 + 32'(i * 4));
        chk("fill.enq_ready", 64'(enq_ready), 64'd0);
        cycle("fill.ninth", 1'b1, 1'b0, 1'b0, 32'h00000013, 32'h999);
        chk("fill.count8", 64'(count), 64'd8);

        // Ordering across the pointer wrap: deq 5, enq 5 more, drain.
        exp_pc = 32'h100;
        for (int i = 0; i < 5; i++) begin
            chk("wrap.pc", 64'(deq_pc), 64'(exp_pc));
            cycle("wrap.deq", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
            exp_pc += 4;
        end
        for (int i = 8; i < 13; i++) cycle("wrap.enq", 1'b1, 1'b0, 1'b0, 32'h00000013, 32'h100 + 32'(i * 4));
        for (int i = 0; i < 8; i++) begin
            chk("wrap.pc", 64'(deq_pc), 64'(exp_pc));
            cycle("wrap.drain", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
            exp_pc += 4;
        end

        // Steady enq+deq at count=4.
        for (int i = 0; i < 4; i++) cycle("steady.fill", 1'b1, 1'b0, 1'b0, 32'h00100093, 32'h300 + 32'(i * 4));
        exp_pc = 32'h300;
        for (int i = 4; i < 24; i++) begin
            chk("steady.pc", 64'(deq_pc), 64'(exp_pc));
            cycle("steady", 1'b1, 1'b1, 1'b0, 32'h00100093, 32'h300 + 32'(i * 4));
            chk("steady.count4", 64'(count), 64'd4);
            exp_pc += 4;
        end

        // Full with deq_ready: the dequeue happens, the enqueue does not.
        for (int i = 0; i < 4; i++) cycle("full.fill", 1'b1, 1'b0, 1'b0, 32'h00000013, 32'h500 + 32'(i * 4));
        cycle("full.both", 1'b1, 1'b1, 1'b0, 32'h00000013, 32'hBAD);
        chk("full.count7", 64'(count), 64'd7);

        // Flush beats a same-cycle enqueue at count=5.
        cycle("flush.pre", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) cycle("flush.fill", 1'b1, 1'b0, 1'b0, 32'h00000013, 32'h600 + 32'(i * 4));
        cycle("flush.enq", 1'b1, 1'b0, 1'b1, 32'h800000EF, 32'h700);
        chk("flush.count0", 64'(count), 64'd0);
        chk("flush.deq_valid", 64'(deq_valid), 64'd0);
        cycle("flush.after", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            if ($urandom_range(0, 3) != 0) w[6:0] = opcs[$urandom_range(0, 10)];
            cycle("rand", 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 40) == 0), w, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
